// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: burst/response encodings, FSM state types and default bus widths.
package axi_pkg;

  localparam int AXI_ADDR_WIDTH  = 16;
  localparam int AXI_DATA_WIDTH  = 32;
  localparam int AXI_LEN_WIDTH   = 8;
  localparam int AXI_SIZE_WIDTH  = 3;
  localparam int AXI_BURST_WIDTH = 2;
  localparam int AXI_RESP_WIDTH  = 2;
  localparam int AXI_ID_WIDTH    = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI4 next-beat address and burst legality check (FIXED/INCR/WRAP).
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH   = AXI_ADDR_WIDTH,
  parameter int LEN_WIDTH    = AXI_LEN_WIDTH,
  parameter int SIZE_WIDTH   = AXI_SIZE_WIDTH,
  parameter int BURST_WIDTH  = AXI_BURST_WIDTH,
  parameter int STROBE_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [LEN_WIDTH-1:0]   len,
  input  logic [SIZE_WIDTH-1:0]  size,
  input  logic [BURST_WIDTH-1:0] burst,
  output logic [ADDR_WIDTH-1:0]  next_addr,
  output logic                   illegal
);

  localparam int MAX_SIZE = $clog2(STROBE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  wrap_len_ok;

  always_comb begin
    incr_addr   = addr + (ADDR_ONE << size);
    // Wrap window is (len+1) beats of 2^size bytes, a power of two for legal lengths
    wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_ONE) << size) - ADDR_ONE;
    wrap_len_ok = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                  (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    next_addr   = addr;
    case (burst)
      BURST_WIDTH'(BURST_INCR): next_addr = incr_addr;
      BURST_WIDTH'(BURST_WRAP): next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:                  next_addr = addr;
    endcase
    illegal = (size > SIZE_WIDTH'(MAX_SIZE)) ||
              (burst == BURST_WIDTH'(BURST_RSVD)) ||
              ((burst == BURST_WIDTH'(BURST_WRAP)) && !wrap_len_ok);
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a word-addressed memory; one outstanding write and one
// outstanding read, each handled by its own FSM.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH   = AXI_ADDR_WIDTH,
  parameter int DATA_WIDTH   = AXI_DATA_WIDTH,
  parameter int LEN_WIDTH    = AXI_LEN_WIDTH,
  parameter int SIZE_WIDTH   = AXI_SIZE_WIDTH,
  parameter int BURST_WIDTH  = AXI_BURST_WIDTH,
  parameter int RESP_WIDTH   = AXI_RESP_WIDTH,
  parameter int ID_WIDTH     = AXI_ID_WIDTH,
  parameter int STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_WORDS    = 256
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESETn,
  input  logic                    axi_AWVALID,
  output logic                    axi_AWREADY,
  input  logic [ID_WIDTH-1:0]     axi_AWID,
  input  logic [ADDR_WIDTH-1:0]   axi_AWADDR,
  input  logic [LEN_WIDTH-1:0]    axi_AWLEN,
  input  logic [SIZE_WIDTH-1:0]   axi_AWSIZE,
  input  logic [BURST_WIDTH-1:0]  axi_AWBURST,
  input  logic                    axi_WVALID,
  output logic                    axi_WREADY,
  input  logic [DATA_WIDTH-1:0]   axi_WDATA,
  input  logic [STROBE_WIDTH-1:0] axi_WSTRB,
  input  logic                    axi_WLAST,
  output logic                    axi_BVALID,
  input  logic                    axi_BREADY,
  output logic [ID_WIDTH-1:0]     axi_BID,
  output logic [RESP_WIDTH-1:0]   axi_BRESP,
  input  logic                    axi_ARVALID,
  output logic                    axi_ARREADY,
  input  logic [ID_WIDTH-1:0]     axi_ARID,
  input  logic [ADDR_WIDTH-1:0]   axi_ARADDR,
  input  logic [LEN_WIDTH-1:0]    axi_ARLEN,
  input  logic [SIZE_WIDTH-1:0]   axi_ARSIZE,
  input  logic [BURST_WIDTH-1:0]  axi_ARBURST,
  output logic                    axi_RVALID,
  input  logic                    axi_RREADY,
  output logic [ID_WIDTH-1:0]     axi_RID,
  output logic [DATA_WIDTH-1:0]   axi_RDATA,
  output logic [RESP_WIDTH-1:0]   axi_RRESP,
  output logic                    axi_RLAST
);

  localparam int IDX_SHIFT = $clog2(STROBE_WIDTH);
  localparam int MEM_AW    = $clog2(MEM_WORDS);
  localparam logic [RESP_WIDTH-1:0] RSP_OK  = RESP_WIDTH'(RESP_OKAY);
  localparam logic [RESP_WIDTH-1:0] RSP_ERR = RESP_WIDTH'(RESP_SLVERR);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Keeps both READY outputs low until the first clock edge after reset release
  logic out_en;
  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) out_en <= 1'b0;
    else              out_en <= 1'b1;
  end

  w_state_e w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]    aw_id_q;
  logic [ADDR_WIDTH-1:0]  w_addr_q, w_next_addr, w_idx_full;
  logic [LEN_WIDTH-1:0]   aw_len_q, w_beat_q;
  logic [SIZE_WIDTH-1:0]  aw_size_q;
  logic [BURST_WIDTH-1:0] aw_burst_q;
  logic                   w_err_q, w_illegal, w_in_range, w_last_beat, w_beat_err;
  logic [MEM_AW-1:0]      w_idx;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .SIZE_WIDTH(SIZE_WIDTH),
    .BURST_WIDTH(BURST_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)
  ) u_w_addr_gen (
    .addr(w_addr_q), .len(aw_len_q), .size(aw_size_q), .burst(aw_burst_q),
    .next_addr(w_next_addr), .illegal(w_illegal)
  );

  assign w_idx_full  = w_addr_q >> IDX_SHIFT;
  assign w_in_range  = w_idx_full < ADDR_WIDTH'(MEM_WORDS);
  assign w_idx       = w_idx_full[MEM_AW-1:0];
  assign w_last_beat = (w_beat_q == aw_len_q);
  assign w_beat_err  = w_illegal || !w_in_range || (axi_WLAST != w_last_beat);

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) w_state_q <= W_IDLE;
    else              w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d   = w_state_q;
    axi_AWREADY = 1'b0;
    axi_WREADY  = 1'b0;
    axi_BVALID  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        axi_AWREADY = out_en;
        if (axi_AWVALID && out_en) w_state_d = W_DATA;
      end
      W_DATA: begin
        axi_WREADY = 1'b1;
        if (axi_WVALID && w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: begin
        axi_BVALID = 1'b1;
        if (axi_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign axi_BID   = axi_BVALID ? aw_id_q : '0;
  assign axi_BRESP = (axi_BVALID && w_err_q) ? RSP_ERR : RSP_OK;

  always_ff @(posedge axi_ACLK) begin
    if (axi_AWVALID && axi_AWREADY) begin
      aw_id_q    <= axi_AWID;
      w_addr_q   <= axi_AWADDR;
      aw_len_q   <= axi_AWLEN;
      aw_size_q  <= axi_AWSIZE;
      aw_burst_q <= axi_AWBURST;
      w_beat_q   <= '0;
      w_err_q    <= 1'b0;
    end else if (axi_WVALID && axi_WREADY) begin
      w_addr_q   <= w_next_addr;
      w_beat_q   <= w_beat_q + LEN_WIDTH'(1);
      w_err_q    <= w_err_q | w_beat_err;
    end
    // Out-of-range beats are dropped; only strobed byte lanes are written
    if (axi_WVALID && axi_WREADY && w_in_range) begin
      for (int b = 0; b < STROBE_WIDTH; b++) begin
        if (axi_WSTRB[b]) mem[w_idx][8*b +: 8] <= axi_WDATA[8*b +: 8];
      end
    end
  end

  r_state_e r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]    ar_id_q;
  logic [ADDR_WIDTH-1:0]  r_addr_q, r_next_addr, r_idx_full;
  logic [LEN_WIDTH-1:0]   ar_len_q, r_beat_q;
  logic [SIZE_WIDTH-1:0]  ar_size_q;
  logic [BURST_WIDTH-1:0] ar_burst_q;
  logic                   r_illegal, r_in_range, r_last_beat;
  logic [MEM_AW-1:0]      r_idx;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .SIZE_WIDTH(SIZE_WIDTH),
    .BURST_WIDTH(BURST_WIDTH), .STROBE_WIDTH(STROBE_WIDTH)
  ) u_r_addr_gen (
    .addr(r_addr_q), .len(ar_len_q), .size(ar_size_q), .burst(ar_burst_q),
    .next_addr(r_next_addr), .illegal(r_illegal)
  );

  assign r_idx_full  = r_addr_q >> IDX_SHIFT;
  assign r_in_range  = r_idx_full < ADDR_WIDTH'(MEM_WORDS);
  assign r_idx       = r_idx_full[MEM_AW-1:0];
  assign r_last_beat = (r_beat_q == ar_len_q);

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) r_state_q <= R_IDLE;
    else              r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d   = r_state_q;
    axi_ARREADY = 1'b0;
    axi_RVALID  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        axi_ARREADY = out_en;
        if (axi_ARVALID && out_en) r_state_d = R_DATA;
      end
      R_DATA: begin
        axi_RVALID = 1'b1;
        if (axi_RREADY && r_last_beat) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Asynchronous array read: a write to the same word at this edge is seen next cycle
  assign axi_RID   = axi_RVALID ? ar_id_q : '0;
  assign axi_RDATA = (axi_RVALID && r_in_range) ? mem[r_idx] : '0;
  assign axi_RRESP = (axi_RVALID && (r_illegal || !r_in_range)) ? RSP_ERR : RSP_OK;
  assign axi_RLAST = axi_RVALID && r_last_beat;

  always_ff @(posedge axi_ACLK) begin
    if (axi_ARVALID && axi_ARREADY) begin
      ar_id_q    <= axi_ARID;
      r_addr_q   <= axi_ARADDR;
      ar_len_q   <= axi_ARLEN;
      ar_size_q  <= axi_ARSIZE;
      ar_burst_q <= axi_ARBURST;
      r_beat_q   <= '0;
    end else if (axi_RVALID && axi_RREADY) begin
      r_addr_q   <= r_next_addr;
      r_beat_q   <= r_beat_q + LEN_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed vector table, hand sequences for multi-cycle
// corners, then random bursts checked against a byte-level memory model.
module tb_axi_mem_responder;
  import axi_pkg::*;

  logic        axi_ACLK = 1'b0;
  logic        axi_ARESETn;
  logic        axi_AWVALID, axi_AWREADY;
  logic [3:0]  axi_AWID;
  logic [15:0] axi_AWADDR;
  logic [7:0]  axi_AWLEN;
  logic [2:0]  axi_AWSIZE;
  logic [1:0]  axi_AWBURST;
  logic        axi_WVALID, axi_WREADY;
  logic [31:0] axi_WDATA;
  logic [3:0]  axi_WSTRB;
  logic        axi_WLAST;
  logic        axi_BVALID, axi_BREADY;
  logic [3:0]  axi_BID;
  logic [1:0]  axi_BRESP;
  logic        axi_ARVALID, axi_ARREADY;
  logic [3:0]  axi_ARID;
  logic [15:0] axi_ARADDR;
  logic [7:0]  axi_ARLEN;
  logic [2:0]  axi_ARSIZE;
  logic [1:0]  axi_ARBURST;
  logic        axi_RVALID, axi_RREADY;
  logic [3:0]  axi_RID;
  logic [31:0] axi_RDATA;
  logic [1:0]  axi_RRESP;
  logic        axi_RLAST;

  always #5 axi_ACLK = ~axi_ACLK;

  axi_mem_responder dut (
    .axi_ACLK(axi_ACLK), .axi_ARESETn(axi_ARESETn),
    .axi_AWVALID(axi_AWVALID), .axi_AWREADY(axi_AWREADY), .axi_AWID(axi_AWID),
    .axi_AWADDR(axi_AWADDR), .axi_AWLEN(axi_AWLEN), .axi_AWSIZE(axi_AWSIZE),
    .axi_AWBURST(axi_AWBURST),
    .axi_WVALID(axi_WVALID), .axi_WREADY(axi_WREADY), .axi_WDATA(axi_WDATA),
    .axi_WSTRB(axi_WSTRB), .axi_WLAST(axi_WLAST),
    .axi_BVALID(axi_BVALID), .axi_BREADY(axi_BREADY), .axi_BID(axi_BID), .axi_BRESP(axi_BRESP),
    .axi_ARVALID(axi_ARVALID), .axi_ARREADY(axi_ARREADY), .axi_ARID(axi_ARID),
    .axi_ARADDR(axi_ARADDR), .axi_ARLEN(axi_ARLEN), .axi_ARSIZE(axi_ARSIZE),
    .axi_ARBURST(axi_ARBURST),
    .axi_RVALID(axi_RVALID), .axi_RREADY(axi_RREADY), .axi_RID(axi_RID), .axi_RDATA(axi_RDATA),
    .axi_RRESP(axi_RRESP), .axi_RLAST(axi_RLAST)
  );

  localparam logic [31:0] GOLD = 32'h9E3779B9;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [256];
  logic [31:0] rd_q [$];
  logic [1:0]  rr_q [$];

  typedef struct {
    bit          wr;
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    int          wl_mode;
    int          exp_resp;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic outputs_zero(input string nm);
    chk(nm, {axi_AWREADY, axi_WREADY, axi_BVALID, axi_BID, axi_BRESP, axi_ARREADY,
             axi_RVALID, axi_RID, axi_RDATA, axi_RRESP, axi_RLAST}, 64'd0);
  endtask

  // Reference address sequence from the burst rules, in plain integer arithmetic
  function automatic logic [15:0] m_next(input logic [15:0] a, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    int bytes, total, lo, nx;
    bytes = 1 << size;
    total = (int'(len) + 1) * bytes;
    if (burst == 2'b01) return 16'((int'(a) + bytes) % 65536);
    if (burst == 2'b10) begin
      lo = int'(a) - (int'(a) % total);
      nx = int'(a) + bytes;
      if (nx >= lo + total) nx -= total;
      return 16'(nx);
    end
    return a;
  endfunction

  function automatic bit m_illegal(input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic [31:0] beat_data(input logic [31:0] seed, input int k);
    return seed ^ (32'(k) * GOLD);
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int wl_mode, input int abort_beat, input logic [31:0] seed,
                          input int exp_resp);
    logic [15:0] a;
    bit err;
    int n, idx;
    a   = addr;
    err = m_illegal(len, size, burst);
    @(negedge axi_ACLK);
    axi_AWID = id; axi_AWADDR = addr; axi_AWLEN = len; axi_AWSIZE = size; axi_AWBURST = burst;
    axi_AWVALID = 1'b1;
    n = 0;
    while (!axi_AWREADY && n < 20) begin @(negedge axi_ACLK); n++; end
    if (n >= 20) begin chk("aw_timeout", 0, 1); axi_AWVALID = 1'b0; return; end
    @(negedge axi_ACLK);
    axi_AWVALID = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      logic wl;
      if ($urandom_range(0, 3) == 0) begin axi_WVALID = 1'b0; @(negedge axi_ACLK); end
      wl = (wl_mode == 0) ? (k == int'(len)) : (wl_mode == 1);
      axi_WDATA = beat_data(seed, k); axi_WSTRB = strb; axi_WLAST = wl; axi_WVALID = 1'b1;
      if (k == abort_beat) begin
        #1 axi_ARESETn = 1'b0;
        #1 outputs_zero("rst_mid_burst_outputs");
        @(negedge axi_ACLK);
        @(negedge axi_ACLK);
        axi_WVALID = 1'b0; axi_WLAST = 1'b0;
        axi_ARESETn = 1'b1;
        #1 chk("awready_before_edge", axi_AWREADY, 0);
        @(posedge axi_ACLK);
        #1 chk("awready_after_release", axi_AWREADY, 1);
        repeat (3) begin @(negedge axi_ACLK); chk("no_bvalid_after_abort", axi_BVALID, 0); end
        return;
      end
      n = 0;
      while (!axi_WREADY && n < 20) begin @(negedge axi_ACLK); n++; end
      if (n >= 20) begin chk("w_timeout", 0, 1); axi_WVALID = 1'b0; return; end
      idx = int'(a) >> 2;
      if (idx < 256) begin
        for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = axi_WDATA[8*b +: 8];
      end else err = 1'b1;
      if (wl != (k == int'(len))) err = 1'b1;
      a = m_next(a, len, size, burst);
      @(negedge axi_ACLK);
    end
    axi_WVALID = 1'b0; axi_WLAST = 1'b0;
    n = 0;
    while (!axi_BVALID && n < 20) begin @(negedge axi_ACLK); n++; end
    if (n >= 20) begin chk("b_timeout", 0, 1); return; end
    repeat ($urandom_range(0, 2)) begin
      @(negedge axi_ACLK);
      chk("bvalid_hold", axi_BVALID, 1);
    end
    chk("bid", axi_BID, id);
    chk("bresp", axi_BRESP, (exp_resp >= 0) ? 64'(exp_resp) : (err ? 64'd2 : 64'd0));
    axi_BREADY = 1'b1;
    @(negedge axi_ACLK);
    axi_BREADY = 1'b0;
    chk("b_done", axi_BVALID, 0);
  endtask

  // stall_mode: 0 always ready, 1 random RREADY, 2 RREADY toggling 0/1
  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_mode,
                         input int exp_first);
    logic [15:0] a;
    logic [31:0] expd, d;
    logic [1:0]  er, rs;
    bit ill, rr, tog, first;
    int n, idx;
    rd_q.delete(); rr_q.delete();
    a   = addr;
    ill = m_illegal(len, size, burst);
    tog = 1'b0;
    first = 1'b1;
    @(negedge axi_ACLK);
    axi_ARID = id; axi_ARADDR = addr; axi_ARLEN = len; axi_ARSIZE = size; axi_ARBURST = burst;
    axi_ARVALID = 1'b1;
    n = 0;
    while (!axi_ARREADY && n < 20) begin @(negedge axi_ACLK); n++; end
    if (n >= 20) begin chk("ar_timeout", 0, 1); axi_ARVALID = 1'b0; return; end
    @(negedge axi_ACLK);
    axi_ARVALID = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      bit done;
      idx  = int'(a) >> 2;
      expd = (idx < 256) ? mdl[idx] : 32'd0;
      er   = (ill || idx >= 256) ? 2'd2 : 2'd0;
      done = 1'b0;
      while (!done) begin
        n = 0;
        while (!axi_RVALID && n < 20) begin @(negedge axi_ACLK); n++; end
        if (n >= 20) begin chk("r_timeout", 0, 1); return; end
        chk("rdata", axi_RDATA, expd);
        chk("rresp", axi_RRESP, er);
        chk("rlast", axi_RLAST, k == int'(len));
        chk("rid", axi_RID, id);
        if (first && exp_first >= 0) chk("rresp_first", axi_RRESP, 64'(exp_first));
        first = 1'b0;
        d  = axi_RDATA;
        rs = axi_RRESP;
        case (stall_mode)
          0:       rr = 1'b1;
          1:       rr = 1'($urandom_range(0, 1));
          default: begin rr = tog; tog = !tog; end
        endcase
        axi_RREADY = rr;
        @(negedge axi_ACLK);
        axi_RREADY = 1'b0;
        if (rr) begin done = 1'b1; rd_q.push_back(d); rr_q.push_back(rs); end
      end
      a = m_next(a, len, size, burst);
    end
    chk("r_done", axi_RVALID, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_w, new_w, s;
    int r, wl;
    logic [1:0]  bu;
    logic [7:0]  ln;
    axi_ARESETn = 1'b0;
    axi_AWVALID = 0; axi_AWID = 0; axi_AWADDR = 0; axi_AWLEN = 0; axi_AWSIZE = 0; axi_AWBURST = 0;
    axi_WVALID = 0; axi_WDATA = 0; axi_WSTRB = 0; axi_WLAST = 0; axi_BREADY = 0;
    axi_ARVALID = 0; axi_ARID = 0; axi_ARADDR = 0; axi_ARLEN = 0; axi_ARSIZE = 0; axi_ARBURST = 0;
    axi_RREADY = 0;

    repeat (3) @(negedge axi_ACLK);
    outputs_zero("reset_outputs");
    axi_ARESETn = 1'b1;
    #1 chk("awready_pre_edge", {axi_AWREADY, axi_ARREADY}, 0);
    @(posedge axi_ACLK);
    #1 chk("ready_first_edge", {axi_AWREADY, axi_ARREADY}, 2'b11);

    do_write(4'h0, 16'h0000, 8'd255, 3'd2, 2'b01, 4'hF, 0, -1, 32'h5A5A0000, 0);

    tbl.push_back('{1'b1, 4'hA, 16'h0000, 8'd7, 3'd2, 2'b01, 4'hF,    0, 0});
    tbl.push_back('{1'b0, 4'hA, 16'h0000, 8'd7, 3'd2, 2'b01, 4'hF,    0, 0});
    tbl.push_back('{1'b1, 4'h3, 16'h0018, 8'd3, 3'd2, 2'b10, 4'hF,    0, 0});
    tbl.push_back('{1'b0, 4'h3, 16'h0018, 8'd3, 3'd2, 2'b10, 4'hF,    0, 0});
    tbl.push_back('{1'b1, 4'h5, 16'h0040, 8'd2, 3'd2, 2'b00, 4'hF,    0, 0});
    tbl.push_back('{1'b1, 4'h1, 16'h03FC, 8'd1, 3'd2, 2'b01, 4'hF,    0, 2});
    tbl.push_back('{1'b0, 4'h1, 16'h03F8, 8'd2, 3'd2, 2'b01, 4'hF,    0, 0});
    tbl.push_back('{1'b1, 4'h2, 16'h0080, 8'd1, 3'd2, 2'b01, 4'hF,    1, 2});
    tbl.push_back('{1'b1, 4'h2, 16'h0088, 8'd1, 3'd2, 2'b01, 4'hF,    2, 2});
    tbl.push_back('{1'b1, 4'h6, 16'h0100, 8'd0, 3'd3, 2'b01, 4'hF,    0, 2});
    tbl.push_back('{1'b1, 4'h7, 16'h0104, 8'd0, 3'd2, 2'b11, 4'hF,    0, 2});
    tbl.push_back('{1'b0, 4'h8, 16'h0100, 8'd0, 3'd2, 2'b10, 4'hF,    0, 2});
    tbl.push_back('{1'b1, 4'h9, 16'h0200, 8'd3, 3'd2, 2'b01, 4'b0110, 0, 0});
    tbl.push_back('{1'b0, 4'h9, 16'h0200, 8'd3, 3'd2, 2'b01, 4'hF,    0, 0});
    tbl.push_back('{1'b0, 4'h4, 16'h0044, 8'd3, 3'd2, 2'b00, 4'hF,    0, 0});
    tbl.push_back('{1'b1, 4'hC, 16'h0021, 8'd3, 3'd0, 2'b01, 4'b0010, 0, 0});
    tbl.push_back('{1'b0, 4'hC, 16'h0020, 8'd1, 3'd2, 2'b01, 4'hF,    0, 0});
    foreach (tbl[i]) begin
      if (tbl[i].wr)
        do_write(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].strb,
                 tbl[i].wl_mode, -1, 32'h1000_0000 + 32'(i), tbl[i].exp_resp);
      else
        do_read(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, 1,
                tbl[i].exp_resp);
    end

    // Partial strobe over a pre-filled word
    do_write(4'h1, 16'h00F0, 8'd0, 3'd2, 2'b01, 4'hF,    0, -1, 32'hFFFFFFFF, 0);
    do_write(4'h1, 16'h00F0, 8'd0, 3'd2, 2'b01, 4'b0101, 0, -1, 32'h12345678, 0);
    do_read(4'h1, 16'h00F0, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("strobe_merge", rd_q[0], 32'hFF34FF78);

    // WRAP beat placement: beats land at 0x18,0x1C,0x10,0x14
    s = 32'hA5A50000;
    do_write(4'h2, 16'h0018, 8'd3, 3'd2, 2'b10, 4'hF, 0, -1, s, 0);
    do_read(4'h2, 16'h0010, 8'd3, 3'd2, 2'b01, 0, 0);
    chk("wrap_word_0x10", rd_q[0], beat_data(s, 2));
    chk("wrap_word_0x14", rd_q[1], beat_data(s, 3));
    chk("wrap_word_0x18", rd_q[2], beat_data(s, 0));
    chk("wrap_word_0x1C", rd_q[3], beat_data(s, 1));

    // Out-of-range read with RREADY toggling
    do_read(4'h3, 16'h0400, 8'd1, 3'd2, 2'b01, 2, 2);
    chk("oob_rdata0", rd_q[0], 0);
    chk("oob_rdata1", rd_q[1], 0);
    chk("oob_rresp0", rr_q[0], 2);
    chk("oob_rresp1", rr_q[1], 2);

    // Same-cycle write and read of word 192
    old_w = mdl[192];
    new_w = 32'hC0FFEE01;
    @(negedge axi_ACLK);
    axi_AWID = 4'h4; axi_AWADDR = 16'h0300; axi_AWLEN = 0; axi_AWSIZE = 3'd2; axi_AWBURST = 2'b01;
    axi_ARID = 4'h5; axi_ARADDR = 16'h0300; axi_ARLEN = 0; axi_ARSIZE = 3'd2; axi_ARBURST = 2'b01;
    axi_AWVALID = 1'b1; axi_ARVALID = 1'b1;
    chk("both_ready", {axi_AWREADY, axi_ARREADY}, 2'b11);
    @(negedge axi_ACLK);
    axi_AWVALID = 1'b0; axi_ARVALID = 1'b0;
    chk("same_cycle_pre_data", axi_RDATA, old_w);
    axi_WDATA = new_w; axi_WSTRB = 4'hF; axi_WLAST = 1'b1; axi_WVALID = 1'b1; axi_RREADY = 1'b1;
    @(negedge axi_ACLK);
    axi_WVALID = 1'b0; axi_WLAST = 1'b0; axi_RREADY = 1'b0;
    chk("same_cycle_r_done", axi_RVALID, 0);
    chk("same_cycle_b", {axi_BVALID, axi_BRESP}, 3'b100);
    axi_BREADY = 1'b1;
    @(negedge axi_ACLK);
    axi_BREADY = 1'b0;
    mdl[192] = new_w;
    do_read(4'h5, 16'h0300, 8'd0, 3'd2, 2'b01, 0, 0);

    // Reset during beat 3 of an 8-beat write
    s = 32'h0BADF00D;
    do_write(4'h6, 16'h0000, 8'd7, 3'd2, 2'b01, 4'hF, 0, 3, s, 0);
    do_read(4'h6, 16'h0000, 8'd3, 3'd2, 2'b01, 0, 0);
    chk("abort_word0", rd_q[0], beat_data(s, 0));
    chk("abort_word1", rd_q[1], beat_data(s, 1));
    chk("abort_word2", rd_q[2], beat_data(s, 2));

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      bu = (r < 2) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      if (bu == 2'b10) begin
        r  = $urandom_range(0, 3);
        ln = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'd3 : 8'd7;
      end else if (bu == 2'b11) ln = 8'd0;
      else ln = 8'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      wl = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      if ($urandom_range(0, 1) == 1)
        do_write(4'($urandom), 16'($urandom_range(0, 16'h04FF)), ln,
                 3'(($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2)), bu,
                 4'($urandom), wl, -1, $urandom, -1);
      else
        do_read(4'($urandom), 16'($urandom_range(0, 16'h04FF)), ln,
                3'(($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2)), bu, 1, -1);
    end

    // Illegal WRAP length; memory contents are not read afterwards
    do_write(4'hE, 16'h0300, 8'd2, 3'd2, 2'b10, 4'hF, 0, -1, 32'h77777777, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH 16, byte address width; DATA_WIDTH 32, data bus width; LEN_WIDTH 8, AxLEN width; SIZE_WIDTH 3, AxSIZE width.
REQ-002 Parameters (cont.): BURST_WIDTH 2, AxBURST width; RESP_WIDTH 2, xRESP width; ID_WIDTH 4, transaction ID width; STROBE_WIDTH DATA_WIDTH/8, WSTRB width; MEM_WORDS 256, storage depth in DATA_WIDTH words.
REQ-003 axi_ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 axi_ARESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 Write request: axi_AWVALID in 1; axi_AWREADY out 1; axi_AWID in ID_WIDTH; axi_AWADDR in ADDR_WIDTH; axi_AWLEN in LEN_WIDTH; axi_AWSIZE in SIZE_WIDTH; axi_AWBURST in BURST_WIDTH.
REQ-006 Write data: axi_WVALID in 1; axi_WREADY out 1; axi_WDATA in DATA_WIDTH; axi_WSTRB in STROBE_WIDTH; axi_WLAST in 1.
REQ-007 Write response: axi_BVALID out 1; axi_BREADY in 1; axi_BID out ID_WIDTH; axi_BRESP out RESP_WIDTH.
REQ-008 Read request: axi_ARVALID in 1; axi_ARREADY out 1; axi_ARID in ID_WIDTH; axi_ARADDR in ADDR_WIDTH; axi_ARLEN in LEN_WIDTH; axi_ARSIZE in SIZE_WIDTH; axi_ARBURST in BURST_WIDTH.
REQ-009 Read data: axi_RVALID out 1; axi_RREADY in 1; axi_RID out ID_WIDTH; axi_RDATA out DATA_WIDTH; axi_RRESP out RESP_WIDTH; axi_RLAST out 1.

Function
REQ-010 Block SHALL be an AXI4 subordinate backed by a MEM_WORDS x DATA_WIDTH array; word index = addr >> log2(STROBE_WIDTH); one outstanding write and one outstanding read, independent FSMs.
REQ-011 Write FSM SHALL have states W_IDLE (AWREADY=1), W_DATA (WREADY=1), W_RESP (BVALID=1); AW handshake latches ID/ADDR/LEN/SIZE/BURST and enters W_DATA next cycle.
REQ-012 In W_DATA each WVALID&WREADY beat SHALL write only bytes with WSTRB set, then advance address and beat counter; beat LEN handshake enters W_RESP next cycle regardless of WLAST.
REQ-013 WLAST high before beat LEN, or low on beat LEN, SHALL set sticky SLVERR for the burst; termination still by beat count.
REQ-014 W_RESP SHALL drive BID=latched AWID, BRESP=00 OKAY or 10 SLVERR, hold until BREADY, then return to W_IDLE.
REQ-015 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1); RVALID rises the cycle after AR handshake; RDATA = mem[current index]; RID = latched ARID; RLAST=1 only on beat ARLEN.
REQ-016 Read beat advances only on RVALID&RREADY; RDATA/RLAST/RRESP SHALL stay stable while RVALID&!RREADY; handshake with RLAST returns to R_IDLE.
REQ-017 Next address: FIXED 00 unchanged; INCR 01 addr+(1<<SIZE), wraps modulo 2^ADDR_WIDTH; WRAP 10 wraps within (LEN+1)<<SIZE aligned boundary; arithmetic in ADDR_WIDTH+1 bits, truncated.
REQ-018 SLVERR SHALL be flagged for: index >= MEM_WORDS (beat dropped on write, RDATA=0 on read), SIZE > log2(STROBE_WIDTH), BURST=11, WRAP with LEN not in {1,3,7,15}; write SLVERR sticky per burst, read RRESP per beat.
REQ-019 Same-cycle write and read of one word: read beat SHALL return pre-write data; write commits at that edge.

Reset
REQ-020 While axi_ARESETn=0 all outputs SHALL be 0 and FSMs in W_IDLE/R_IDLE; AWREADY/ARREADY SHALL first assert on the first rising edge after release.
REQ-021 Reset mid-burst SHALL abandon the burst with no response issued; memory array contents SHALL NOT be reset.

Structure
REQ-022 Shared package axi_pkg SHALL hold burst enum (FIXED/INCR/WRAP), resp enum (OKAY/EXOKAY/SLVERR/DECERR) and default width constants.
REQ-023 One sub-module axi_burst_addr_gen (combinational next-address + legality check) SHALL be instantiated twice, write and read paths.

Verification
REQ-024 AW 0x0000 LEN 7 SIZE 2 INCR ID 0xA, 8 beats WSTRB 1111 -> BVALID with BID 0xA BRESP 00; AR same -> 8 beats identical data, RLAST only beat 7, RRESP 00.
REQ-025 Write 0x00F0 WSTRB 0101 over pre-filled 0xFFFFFFFF with 0x12345678 -> read returns 0xFF34FF78.
REQ-026 WRAP LEN 3 SIZE 2 at 0x0018 -> beats hit 0x18,0x1C,0x10,0x14; LEN 2 WRAP -> BRESP 10.
REQ-027 AR at 0x0400 (index 256) LEN 1 -> two beats RDATA 0 RRESP 10; RREADY toggled 1/0 -> data stable while stalled.
REQ-028 Reset asserted at write beat 3 -> all outputs 0 immediately; after release AWREADY=1 next edge, no BVALID, words 0-2 retain written data.
